qft_mac_seq: RTL and testbench
==============================

Name: qft_mac_seq

Overview:
- Parametrised sequencer for the signed complex multiply-accumulate datapath in the QFT simulator hardware.
- Walks a vector of `len` amplitude/twiddle pairs. For each pair it issues a multiply, waits out the multiplier pipeline, then accumulates into one of `N_LANES` lane accumulators, selected round-robin.
- Optionally finishes with a magnitude (abs) pass.
- Sits between the top-level job controller (start/done handshake) and the signed arithmetic datapath (enables, selects, operand address).

Parameters:
- N_LANES, 1, number of lane accumulators; `sel` width (>=1).
- LEN_W, 8, width of vector length and operand address.
- MUL_LAT, 3, multiplier pipeline latency in cycles (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin job; sampled only in IDLE
- len  in  LEN_W  number of pairs; sampled with start
- mode  in  1  0 = accumulate only, 1 = accumulate then abs pass; sampled with start
- abort  in  1  cancel job; returns to IDLE with no done
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job completion
- addr  out  LEN_W  operand index for the current pair
- sel  out  N_LANES  one-hot lane select = 1 << (addr mod N_LANES)
- acc_clr  out  1  clear all lane accumulators
- mul_en  out  1  issue multiply on addr
- acc_en  out  1  add multiplier result into lane `sel`
- abs_en  out  1  magnitude pass over all lanes

Behaviour:
- Reset: state IDLE. All outputs 0; `sel` = 0; internal index and latency counter = 0. Reset takes priority over `abort` and `start`.
- Registered outputs are decoded from the current state. `sel` is 0 outside MUL, WAIT and ACC.
- States and transitions:
  - IDLE: on start with len != 0, latch len and mode, set idx = 0, go to CLR. On start with len == 0, go to DONE. With no start, stay in IDLE.
  - CLR: `acc_clr` = 1 for one cycle; go to MUL.
  - MUL: `mul_en` = 1 and addr = idx. If MUL_LAT == 1 go to ACC; otherwise go to WAIT with wcnt = MUL_LAT - 2.
  - WAIT: hold addr and sel. Decrement wcnt; go to ACC when wcnt == 0. Residency is MUL_LAT - 1 cycles.
  - ACC: `acc_en` = 1 with `sel` for idx.
    - If idx == len_q - 1: go to ABS when mode_q = 1, else go to DONE.
    - Otherwise increment idx and go to MUL.
  - ABS: `abs_en` = 1 for one cycle; go to DONE.
  - DONE: `done` = 1 and `busy` = 1 for one cycle; go to IDLE.
- Per-pair cost is MUL_LAT + 1 cycles.
- Job length from the start edge to the done cycle inclusive: 1 + len*(MUL_LAT+1) + mode + 1 cycles.
- `start` while busy is ignored; no queueing.
- `len`/`mode` changes while busy are ignored (latched copies are used).
- `abort` in any non-IDLE state:
  - next state is IDLE and all outputs drop to 0 next cycle;
  - `done` is not pulsed;
  - abort in DONE still suppresses nothing, because `done` has already pulsed that cycle.
- `abort` in IDLE is a no-op. `abort` and `start` together in IDLE: `abort` wins and the block stays in IDLE.
- len = 2^LEN_W - 1: idx reaches its max without wrap; no overflow.
- Lane wrap: sel cycles 1 << 0 … 1 << (N_LANES-1), then returns to 1 << 0. With N_LANES = 1, sel is constantly 1 in MUL/WAIT/ACC.
- Reset mid-job behaves like `abort`, plus all counters are cleared.

Test Plan:
- N_LANES=4, MUL_LAT=3, len=5, mode=0, start pulse:
  - sequence is CLR, then (MUL, WAIT×2, ACC)×5, then DONE;
  - `done` at cycle 22 after start;
  - acc_en sel values 0001, 0010, 0100, 1000, 0001;
  - addr 0..4.
- Same job with mode=1: single `abs_en` cycle immediately after the last ACC; `done` one cycle later, at cycle 23.
- MUL_LAT=1, len=3, mode=0: no WAIT cycles; mul_en/acc_en alternate; `done` at cycle 8.
- len=0 start: next cycle `done` = 1 and `busy` = 1; no acc_clr, mul_en or acc_en ever.
- Abort asserted on the second WAIT cycle of pair 2:
  - next cycle all outputs are 0 and busy = 0;
  - `done` never asserted;
  - a following start with len=1 runs cleanly from addr 0.
- `start` re-pulsed with len=9 during a busy len=2 job: ignored, job ends after 2 pairs. rst mid-ACC: all outputs 0 next cycle.

Source files
------------

// File: rtl/qft_mac_seq.sv
// qft_mac_seq: sequences the complex MAC datapath over a vector of amplitude/twiddle pairs
module qft_mac_seq #(
   parameter int N_LANES = 1,
   parameter int LEN_W   = 8,
   parameter int MUL_LAT = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LEN_W-1:0]   len,
   input  logic               mode,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [LEN_W-1:0]   addr,
   output logic [N_LANES-1:0] sel,
   output logic               acc_clr,
   output logic               mul_en,
   output logic               acc_en,
   output logic               abs_en
);
   localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam int WW = $clog2(MUL_LAT + 1);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_MUL, S_WAIT, S_ACC, S_ABS, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             mode_q, mode_d;
   logic [LW-1:0]    lane_q, lane_d;
   logic [WW-1:0]    wcnt_q, wcnt_d;
   logic             act;

   // state and job registers; the lane counter tracks idx mod N_LANES without a divider
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         mode_q  <= 1'b0;
         lane_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         mode_q  <= mode_d;
         lane_q  <= lane_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // next-state logic; abort from any busy state overrides the normal transition
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      mode_d  = mode_q;
      lane_d  = lane_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_IDLE: if (start && !abort) begin
            len_d   = len;
            mode_d  = mode;
            idx_d   = '0;
            lane_d  = '0;
            state_d = (len == '0) ? S_DONE : S_CLR;
         end
         S_CLR: state_d = S_MUL;
         S_MUL: begin
            state_d = (MUL_LAT == 1) ? S_ACC : S_WAIT;
            wcnt_d  = WW'(MUL_LAT - 2);
         end
         S_WAIT: begin
            wcnt_d  = (wcnt_q == '0) ? wcnt_q : wcnt_q - WW'(1);
            state_d = (wcnt_q == '0) ? S_ACC : S_WAIT;
         end
         S_ACC: if (idx_q == len_q - LEN_W'(1)) state_d = mode_q ? S_ABS : S_DONE;
         else begin
            idx_d   = idx_q + LEN_W'(1);
            lane_d  = (lane_q == LW'(N_LANES - 1)) ? '0 : lane_q + LW'(1);
            state_d = S_MUL;
         end
         S_ABS:   state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      if (abort && state_q != S_IDLE) state_d = S_IDLE;
   end

   // outputs decoded from the current state; addr and sel only live during a pair
   always_comb begin
      act     = (state_q == S_MUL) || (state_q == S_WAIT) || (state_q == S_ACC);
      busy    = state_q != S_IDLE;
      done    = state_q == S_DONE;
      acc_clr = state_q == S_CLR;
      mul_en  = state_q == S_MUL;
      acc_en  = state_q == S_ACC;
      abs_en  = state_q == S_ABS;
      addr    = act ? idx_q : '0;
      sel     = act ? N_LANES'(1) << lane_q : '0;
   end
endmodule

// File: tb/tb_qft_mac_seq.sv
// tb_qft_mac_seq: directed scoreboard bench for the MAC sequencer (4 lanes/lat 3 and 1 lane/lat 1)
module tb_qft_mac_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start1 = 1'b0;
   logic [7:0] len = '0;
   logic       mode = 1'b0;
   logic       abort = 1'b0;

   logic       busy0, done0, acc_clr0, mul_en0, acc_en0, abs_en0;
   logic [7:0] addr0;
   logic [3:0] sel0;
   logic       busy1, done1, acc_clr1, mul_en1, acc_en1, abs_en1;
   logic [7:0] addr1;
   logic [0:0] sel1;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0, last_acc = -10, n_clr = 0, n_abs = 0, n_done = 0;
   logic [11:0] q[$];

   always #5 clk = ~clk;

   qft_mac_seq #(.N_LANES(4), .LEN_W(8), .MUL_LAT(3)) dut0 (
      .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .abort(abort),
      .busy(busy0), .done(done0), .addr(addr0), .sel(sel0), .acc_clr(acc_clr0),
      .mul_en(mul_en0), .acc_en(acc_en0), .abs_en(abs_en0));

   qft_mac_seq #(.N_LANES(1), .LEN_W(8), .MUL_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .len(len), .mode(mode), .abort(abort),
      .busy(busy1), .done(done1), .addr(addr1), .sel(sel1), .acc_clr(acc_clr1),
      .mul_en(mul_en1), .acc_en(acc_en1), .abs_en(abs_en1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard monitor: every accumulate must match the next expected {addr, sel}
   always @(negedge clk) begin
      cyc++;
      if (acc_clr0) n_clr++;
      if (done0) n_done++;
      if (acc_en0) begin
         if (q.size() == 0) check("acc_unexpected", {addr0, sel0}, 32'hffff_ffff);
         else check("acc_pair", {addr0, sel0}, q.pop_front());
         last_acc = cyc;
      end
      if (abs_en0) begin
         n_abs++;
         check("abs_after_last_acc", cyc, last_acc + 1);
      end
   end

   task automatic push_pairs(input int l);
      for (int i = 0; i < l; i++) q.push_back({8'(i), 4'(1 << (i % 4))});
   endtask

   task automatic go(input int l, input bit m, input bit rp);
      int n, c0, a0;
      c0 = n_clr;
      a0 = n_abs;
      @(negedge clk);
      start = 1'b1;
      len = 8'(l);
      mode = m;
      push_pairs(l);
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done0 && n < 300) begin
         if (rp && n == 3) begin
            start = 1'b1;
            len = 8'd9;
         end else start = 1'b0;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("done_latency", n, (l == 0) ? 1 : 2 + 4 * l + int'(m));
      check("busy_at_done", busy0, 1'b1);
      @(negedge clk);
      check("done_one_cycle", {busy0, done0}, 2'b00);
      check("queue_drained", q.size(), 0);
      check("clr_count", n_clr - c0, (l != 0) ? 1 : 0);
      check("abs_count", n_abs - a0, (l != 0 && m) ? 1 : 0);
   endtask

   initial begin
      int d0;
      bit found;
      logic [31:0] exp;
      repeat (2) @(negedge clk);
      check("reset_dut0", {busy0, done0, acc_clr0, mul_en0, acc_en0, abs_en0, addr0, sel0}, 0);
      check("reset_dut1", {busy1, done1, acc_clr1, mul_en1, acc_en1, abs_en1, addr1, sel1}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", busy0, 1'b0);

      go(5, 1'b0, 1'b0);
      go(5, 1'b1, 1'b0);
      d0 = n_clr;
      go(0, 1'b1, 1'b0);
      check("len0_no_clr", n_clr - d0, 0);

      @(negedge clk);
      start1 = 1'b1;
      len = 8'd3;
      mode = 1'b0;
      @(negedge clk);
      start1 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         exp = {19'd0, k == 1, (k >= 2 && k <= 7 && k % 2 == 0), (k >= 3 && k <= 7 && k % 2 == 1),
                k == 8, (k >= 2 && k <= 7) ? 8'((k - 2) / 2) : 8'd0, (k >= 2 && k <= 7)};
         check("lat1_sequence", {19'd0, acc_clr1, mul_en1, acc_en1, done1, addr1, sel1}, exp);
         @(negedge clk);
      end
      check("lat1_idle", busy1, 1'b0);

      @(negedge clk);
      abort = 1'b1;
      start = 1'b1;
      len = 8'd4;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      check("abort_beats_start", busy0, 1'b0);

      @(negedge clk);
      start = 1'b1;
      len = 8'd5;
      push_pairs(5);
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (mul_en0 && addr0 == 8'd2) found = 1'b1;
         else @(negedge clk);
      end
      check("abort_reach_pair2", found, 1'b1);
      repeat (2) @(negedge clk);
      check("abort_in_wait2", {mul_en0, acc_en0, addr0, sel0}, {2'b00, 8'd2, 4'b0100});
      abort = 1'b1;
      d0 = n_done;
      @(negedge clk);
      abort = 1'b0;
      check("abort_outputs", {busy0, done0, acc_clr0, mul_en0, acc_en0, abs_en0, addr0, sel0}, 0);
      check("abort_pending", q.size(), 3);
      q.delete();
      repeat (5) @(negedge clk);
      check("abort_no_done", n_done - d0, 0);
      go(1, 1'b0, 1'b0);

      go(2, 1'b0, 1'b1);

      @(negedge clk);
      start = 1'b1;
      len = 8'd3;
      push_pairs(3);
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (acc_en0) found = 1'b1;
         else @(negedge clk);
      end
      check("rst_reach_acc", found, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_acc", {busy0, done0, acc_clr0, mul_en0, acc_en0, abs_en0, addr0, sel0}, 0);
      q.delete();
      go(4, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
